// File: rtl/uart_com_link_pkg.sv
// Shared types and helpers for the parametrised UART link layer.
package uart_com_pkg;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

    localparam int unsigned FRAME_BITS = 10;

    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_com_link_if.sv
// Byte-level handshake between uart_com_link and debug_busmaster.
interface uart_com_link_if;

    logic [7:0] i_tx_data;
    logic       i_tx_strobe;
    logic [7:0] o_rx_data;
    logic       o_rx_strobe;

    modport master (output i_tx_data, output i_tx_strobe, input o_rx_data, input o_rx_strobe);
    modport slave  (input i_tx_data, input i_tx_strobe, output o_rx_data, output o_rx_strobe);

endinterface

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with registered read; full/empty from pre-cycle occupancy.
module uart_byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [7:0]               wdata_i,
    output logic [7:0]               rdata_o,
    output logic [$clog2(DEPTH):0]   fill_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_byte_fifo: DEPTH must be a power of two >= 2");
    end

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   fill_q, fill_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          do_push, do_pop;

    assign full_o  = (fill_q == (AW+1)'(DEPTH));
    assign empty_o = (fill_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign fill_o  = fill_q;
    assign rdata_o = rdata_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        rdata_d  = rdata_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            rdata_d  = mem_q[rd_ptr_q];
        end
        unique case ({do_push, do_pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            rdata_q  <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_com_link.sv
// 8N1 UART link layer: oversampling receiver with glitch/framing checks and FIFO-fed transmitter.
module uart_com_link
    import uart_com_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 48000000,
    parameter int unsigned BAUD        = 3000000,
    parameter int unsigned TX_DEPTH    = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      uart_rx,
    output logic                      uart_tx,
    uart_com_link_if.slave            com,
    output logic [$clog2(TX_DEPTH):0] o_tx_fill,
    output logic                      o_tx_idle,
    output logic                      o_tx_overflow,
    output logic [7:0]                o_frame_err_cnt
);
    localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);
    localparam int unsigned CW  = $clog2(DIV);

    if (DIV < 4) begin : g_bad_div
        $error("uart_com_link: CLK_HZ/BAUD must be >= 4");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("uart_com_link: SYNC_STAGES must be >= 2");
    end

    // ---------------- receiver ----------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s, rx_prev_q;
    rx_state_e              rx_state_q, rx_state_d;
    logic [CW-1:0]          rx_cnt_q, rx_cnt_d;
    logic [2:0]             rx_bit_q, rx_bit_d;
    logic [7:0]             rx_shift_q, rx_shift_d, rx_data_q, rx_data_d, err_q, err_d;
    logic                   rx_strobe_q, rx_strobe_d;

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= '1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_strobe_q <= 1'b0;
            err_q       <= '0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], uart_rx};
            rx_prev_q   <= rx_s;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_strobe_q <= rx_strobe_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_strobe_d = 1'b0;
        err_d       = err_q;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = CW'(DIV / 2 - 1);
                end
            end
            RX_START: begin
                if (rx_cnt_q == '0) begin
                    // A start bit that is high again at mid-bit was only a glitch.
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                    rx_cnt_d   = CW'(DIV - 1);
                    rx_bit_d   = '0;
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    rx_cnt_d   = CW'(DIV - 1);
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == '0) begin
                    if (rx_s) begin
                        rx_data_d   = rx_shift_q;
                        rx_strobe_d = 1'b1;
                    end else if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        com.o_rx_data   = rx_data_q;
        com.o_rx_strobe = rx_strobe_q;
        o_frame_err_cnt = err_q;
    end

    // ---------------- transmitter ----------------
    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d, fifo_rdata;
    logic          ovf_q, ovf_d, tx_pop, fifo_full, fifo_empty;

    uart_byte_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (com.i_tx_strobe),
        .pop_i   (tx_pop),
        .wdata_i (com.i_tx_data),
        .rdata_o (fifo_rdata),
        .fill_o  (o_tx_fill),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            ovf_q      <= ovf_d;
        end
    end

    // The popped byte appears on fifo_rdata one cycle later, so it is loaded at the end of TX_START.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        ovf_d      = ovf_q | (com.i_tx_strobe & fifo_full);
        unique case (tx_state_q)
            TX_IDLE: begin
                if (tx_pop) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = CW'(DIV - 1);
                end
            end
            TX_START: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = CW'(DIV - 1);
                    tx_bit_d   = '0;
                    tx_shift_d = fifo_rdata;
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    tx_cnt_d   = CW'(DIV - 1);
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = tx_pop ? TX_START : TX_IDLE;
                    tx_cnt_d   = CW'(DIV - 1);
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Popping at the last stop-bit clock lets the next start bit follow with no idle gap.
    always_comb begin
        tx_pop        = 1'b0;
        uart_tx       = 1'b1;
        unique case (tx_state_q)
            TX_IDLE:  tx_pop  = !fifo_empty;
            TX_START: uart_tx = 1'b0;
            TX_DATA:  uart_tx = tx_shift_q[0];
            TX_STOP:  tx_pop  = !fifo_empty && (tx_cnt_q == '0);
            default:  uart_tx = 1'b1;
        endcase
        o_tx_idle     = fifo_empty && (tx_state_q == TX_IDLE);
        o_tx_overflow = ovf_q;
    end

endmodule

// File: tb/tb_uart_com_link.sv
// Scoreboard bench for uart_com_link at DIV=16: RX frames, glitch, framing errors, TX burst, reset.
module tb_uart_com_link;

    localparam int unsigned DIV      = 16;
    localparam int unsigned SYNC     = 2;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned RX_LAT   = SYNC + DIV / 2 + 9 * DIV + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic       uart_tx;
    logic [4:0] tx_fill;
    logic       tx_idle, tx_ovf;
    logic [7:0] ferr;

    uart_com_link_if bus ();

    uart_com_link #(
        .CLK_HZ      (16000000),
        .BAUD        (1000000),
        .TX_DEPTH    (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .uart_rx         (uart_rx),
        .uart_tx         (uart_tx),
        .com             (bus),
        .o_tx_fill       (tx_fill),
        .o_tx_idle       (tx_idle),
        .o_tx_overflow   (tx_ovf),
        .o_frame_err_cnt (ferr)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    logic [7:0]  rx_exp_q[$];
    int unsigned rx_t0_q[$];
    logic [7:0]  tx_exp_q[$];
    int unsigned rx_strobes = 0;
    int unsigned tx_frames = 0;
    int unsigned tx_prev_start = 0;
    int unsigned tx_push0_cyc = 0;
    bit          tx_mon_en = 1'b0;

    // RX scoreboard: every strobe must match the oldest expected byte and its latency.
    always @(negedge clk) begin
        if (!rst && bus.o_rx_strobe === 1'b1) begin
            rx_strobes++;
            if (rx_exp_q.size() == 0) begin
                check_eq("rx_spurious_strobe", 1, 0);
            end else begin
                logic [7:0]  e;
                int unsigned t0, lat;
                e   = rx_exp_q.pop_front();
                t0  = rx_t0_q.pop_front();
                lat = cyc - t0;
                check_eq("rx_data", bus.o_rx_data, e);
                check_eq("rx_latency_window", (lat + 1 >= RX_LAT) && (lat <= RX_LAT + 1), 1);
            end
        end
    end

    // TX decoder: samples mid-bit, checks framing, order and frame-to-frame spacing.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_mon_en && !rst && uart_tx === 1'b0) begin
                int unsigned start;
                logic [7:0]  b;
                start = cyc;
                if (tx_frames == 0) check_eq("tx_first_latency", start - tx_push0_cyc, 2);
                else                check_eq("tx_frame_spacing", start - tx_prev_start, 10 * DIV);
                tx_prev_start = start;
                repeat (DIV / 2) @(negedge clk);
                check_eq("tx_start_bit", uart_tx, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (DIV) @(negedge clk);
                check_eq("tx_stop_bit", uart_tx, 1);
                if (tx_exp_q.size() == 0) check_eq("tx_spurious_frame", 1, 0);
                else                      check_eq("tx_byte", b, tx_exp_q.pop_front());
                tx_frames++;
                repeat (DIV / 2 - 1) @(negedge clk);
            end
        end
    end

    task automatic send_rx(input logic [7:0] b, input bit stop, input bit expect_ok);
        @(negedge clk);
        if (expect_ok) begin
            rx_exp_q.push_back(b);
            rx_t0_q.push_back(cyc);
        end
        uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = stop;
        repeat (DIV) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    initial begin
        int unsigned bad, s0, mfill;
        bus.i_tx_data   = '0;
        bus.i_tx_strobe = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_uart_tx", uart_tx, 1);
        check_eq("rst_rx_strobe", bus.o_rx_strobe, 0);
        check_eq("rst_rx_data", bus.o_rx_data, 0);
        check_eq("rst_tx_fill", tx_fill, 0);
        check_eq("rst_tx_idle", tx_idle, 1);
        check_eq("rst_tx_overflow", tx_ovf, 0);
        check_eq("rst_frame_err", ferr, 0);
        rst = 1'b0;

        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || tx_idle !== 1'b1 || tx_fill !== '0 ||
                ferr !== '0 || bus.o_rx_strobe !== 1'b0) bad++;
        end
        check_eq("idle_quiet_cycles", bad, 0);

        s0 = rx_strobes;
        send_rx(8'hA5, 1'b1, 1'b1);
        repeat (40) @(negedge clk);
        check_eq("rx_a5_strobe_count", rx_strobes - s0, 1);
        check_eq("rx_a5_pending", rx_exp_q.size(), 0);
        check_eq("rx_a5_frame_err", ferr, 0);

        s0 = rx_strobes;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        check_eq("rx_glitch_no_strobe", rx_strobes - s0, 0);
        send_rx(8'h3C, 1'b1, 1'b1);
        repeat (40) @(negedge clk);
        check_eq("rx_3c_strobe_count", rx_strobes - s0, 1);
        check_eq("rx_3c_pending", rx_exp_q.size(), 0);

        s0 = rx_strobes;
        send_rx(8'h55, 1'b0, 1'b0);
        repeat (2 * DIV) @(negedge clk);
        check_eq("rx_framing_err_1", ferr, 1);
        for (int n = 1; n < 300; n++) begin
            send_rx(8'h55, 1'b0, 1'b0);
            repeat (2 * DIV) @(negedge clk);
        end
        check_eq("rx_framing_err_sat", ferr, 255);
        check_eq("rx_framing_no_strobe", rx_strobes - s0, 0);

        tx_mon_en = 1'b1;
        mfill = 0;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            bus.i_tx_data   = 8'(i);
            bus.i_tx_strobe = 1'b1;
            if (i == 1) tx_push0_cyc = cyc;
            if (mfill < DEPTH) begin
                tx_exp_q.push_back(8'(i));
                mfill++;
            end
            if (i == 2) mfill--;
        end
        @(negedge clk);
        bus.i_tx_strobe = 1'b0;
        check_eq("tx_fill_after_burst", tx_fill, mfill);
        check_eq("tx_overflow_sticky", tx_ovf, 1);
        check_eq("tx_busy_not_idle", tx_idle, 0);
        for (int t = 0; t < 20 * 10 * DIV && tx_exp_q.size() != 0; t++) @(negedge clk);
        repeat (20) @(negedge clk);
        check_eq("tx_drain_pending", tx_exp_q.size(), 0);
        check_eq("tx_frames_sent", tx_frames, 17);
        check_eq("tx_idle_after_drain", tx_idle, 1);
        check_eq("tx_fill_after_drain", tx_fill, 0);

        tx_mon_en = 1'b0;
        @(negedge clk);
        bus.i_tx_data   = 8'h80;
        bus.i_tx_strobe = 1'b1;
        @(negedge clk);
        bus.i_tx_data   = 8'h81;
        @(negedge clk);
        bus.i_tx_strobe = 1'b0;
        repeat (2 + DIV + 40) @(negedge clk);
        check_eq("tx_mid_data_low", uart_tx, 0);
        #2 rst = 1'b1;
        #1 check_eq("tx_async_reset_high", uart_tx, 1);
        @(negedge clk);
        check_eq("rst_mid_fill", tx_fill, 0);
        check_eq("rst_mid_idle", tx_idle, 1);
        rst = 1'b0;
        bad = 0;
        repeat (400) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) bad++;
        end
        check_eq("tx_nothing_after_rst", bad, 0);
        check_eq("tx_overflow_cleared", tx_ovf, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_com_link.md
# uart_com_link

Parametrised UART link layer that sits between the board UART pins and `debug_busmaster`, replacing the fixed 48 MHz / 3 Mbaud RX/TX pair. It carries configurable clock/baud ratio, a metastability-safe oversampling receiver with start-bit glitch rejection and framing-error detection, and a TX byte FIFO. With the FIFO, back-to-back `o_com_strobe` bytes from the busmaster are no longer lost while the transmitter is busy.

## Interface
- `CLK_HZ`, 48000000, system clock frequency in Hz.
- `BAUD`, 3000000, line rate; `DIV = CLK_HZ / BAUD` must be ≥ 4 (elaboration error otherwise).
- `TX_DEPTH`, 16, TX FIFO depth; power of two, ≥ 2.
- `SYNC_STAGES`, 2, RX input synchroniser flops, ≥ 2.

- `clk`  in  1  system clock, all logic rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `uart_rx`  in  1  serial input, idle high, asynchronous to `clk`.
- `uart_tx`  out  1  serial output, idle high.
- `o_rx_data`  out  8  received byte; valid while `o_rx_strobe`.
- `o_rx_strobe`  out  1  one-cycle pulse per good byte; feeds `i_com_strobe` of `debug_busmaster`.
- `i_tx_data`  in  8  byte to send; fed from `o_com_data`.
- `i_tx_strobe`  in  1  one-cycle push request; fed from `o_com_strobe`.
- `o_tx_fill`  out  $clog2(TX_DEPTH)+1  current FIFO occupancy.
- `o_tx_idle`  out  1  FIFO empty and TX state IDLE.
- `o_tx_overflow`  out  1  sticky: a push arrived while FIFO full.
- `o_frame_err_cnt`  out  8  saturating count of framing errors.

## Operation
- Frame format: 8N1, LSB first. One bit = `DIV` clocks.
- RX path: `uart_rx` passes `SYNC_STAGES` flops.
- RX FSM `RX_IDLE` → `RX_START` → `RX_DATA` → `RX_STOP`:
  - `RX_IDLE`: synced high→low edge → `RX_START`, counter loaded with `DIV/2 - 1`.
  - `RX_START`: at counter 0, sample; if high (glitch) → `RX_IDLE`, no output; else → `RX_DATA`, counter `DIV - 1`.
  - `RX_DATA`: sample at each counter expiry into shift reg LSB-first. After 8 bits → `RX_STOP`.
  - `RX_STOP`: sample at expiry. If 1: latch byte, pulse `o_rx_strobe` next cycle. If 0: no strobe; `o_frame_err_cnt` +1, saturating at 255. Either way → `RX_IDLE`; new start edge is accepted immediately (no wait for line idle beyond the sample).
- TX FIFO: synchronous, `TX_DEPTH` entries, registered read.
  - Push on `i_tx_strobe` if not full. If full: byte dropped, `o_tx_overflow` set until `rst`.
  - Full is evaluated on pre-cycle occupancy, so push while full with simultaneous pop is dropped.
  - Push into empty FIFO with TX idle is legal and starts transmission.
- TX FSM `TX_IDLE` → `TX_START` → `TX_DATA` → `TX_STOP`:
  - `TX_IDLE`: if FIFO non-empty, pop, load shift reg → `TX_START`.
  - `TX_START`: drive 0 for `DIV` clocks.
  - `TX_DATA`: drive 8 bits, `DIV` each, LSB first.
  - `TX_STOP`: drive 1 for `DIV` clocks → `TX_IDLE`.
  - Back-to-back frames: the next start bit follows the stop bit with no extra idle clocks.

## Timing
- Reset values: `uart_tx`=1, `o_rx_strobe`=0, `o_rx_data`=0, `o_tx_fill`=0, `o_tx_idle`=1, `o_tx_overflow`=0, `o_frame_err_cnt`=0. Both FSMs go to IDLE and the FIFO is emptied.
- Reset mid-frame: `uart_tx` goes high asynchronously; the partial frame is abandoned and not resent.
- RX latency: `o_rx_strobe` asserts `SYNC_STAGES + DIV/2 + 9*DIV + 1` clocks (±1) after the start-bit falling edge on the pin.
- TX latency: `uart_tx` falls 2 clocks after `i_tx_strobe` into an empty FIFO with TX idle (push cycle, then pop/registered read).
- Frame length: exactly `10*DIV` clocks.
- `o_tx_fill`/`o_tx_idle` update the cycle after push/pop.

## Structure
- Package `uart_com_pkg`:
  - `rx_state_e`, `tx_state_e` enums.
  - Function `calc_div(clk_hz, baud)`.
  - Constant `FRAME_BITS = 10`.
- Sub-module `uart_byte_fifo` (params `DEPTH`, width 8; ports push/pop/data/fill/full/empty).
- The RX and TX FSMs stay in `uart_com_link`.
- `uart_busmaster` instantiates `uart_com_link` in place of its fixed RX/TX instances; simulation builds bypass it as before.

## Test plan
All scenarios use `DIV=16`.
1. Reset release, no stimulus → `uart_tx`=1 constant, `o_tx_idle`=1, all counters 0 for 1000 clocks.
2. Drive frame 0xA5 on `uart_rx` → exactly one `o_rx_strobe` with `o_rx_data`=0xA5 at the specified latency; `o_frame_err_cnt`=0.
3. 4-clock low glitch on `uart_rx` → no strobe; FSM returns to IDLE. Then a valid 0x3C frame is received correctly.
4. Frame 0x55 with stop bit 0 → no strobe, `o_frame_err_cnt`=1. Repeat 300× → count saturates at 255.
5. Push 0x01..0x12 (18 bytes) on consecutive clocks, `TX_DEPTH=16`:
   - first byte popped early; bytes beyond FIFO space dropped, `o_tx_overflow`=1;
   - decoded `uart_tx` stream is the in-order accepted bytes, each `160` clocks apart with no gaps.
6. Assert `rst` mid-`TX_DATA` of byte 0x80 → `uart_tx`=1 within the same cycle; FIFO empty; nothing further transmitted after release.
